// File: rtl/instr_load_sink.sv
// rtl/instr_load_sink.sv - serial instruction-load sink with registered fetch port
module instr_load_sink #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              LoadInstructions,
    input  logic [31:0]       Instruction,
    input  logic              fetch_en,
    input  logic [31:0]       PC,
    output logic [31:0]       InstrOut,
    output logic [ADDR_W:0]   load_count,
    output logic              ready,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   wr_ptr;
    logic [31:0]       mem [DEPTH];

    logic              full;
    logic              load_start;
    logic              load_word;
    logic              load_drop;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_ok;
    logic              fetch_go;

    assign full       = (wr_ptr == DEPTH_C);
    // A load strobe outside LOADING always restarts the image at word 0.
    assign load_start = LoadInstructions && (state != LOADING);
    assign load_word  = LoadInstructions && (state == LOADING) && !full;
    assign load_drop  = LoadInstructions && (state == LOADING) && full;
    assign wr_en      = Reset && (load_start || load_word);
    assign wr_idx     = load_start ? '0 : wr_ptr[ADDR_W-1:0];

    assign fetch_idx  = PC[ADDR_W+1:2];
    assign fetch_ok   = (PC[1:0] == 2'b00)
                     && (PC[31:ADDR_W+2] == '0)
                     && ({1'b0, fetch_idx} < wr_ptr);
    // A concurrent load strobe pre-empts the fetch.
    assign fetch_go   = (state == READY) && fetch_en && !LoadInstructions;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (LoadInstructions) begin
                    state_nxt = LOADING;
                end
            end
            LOADING: begin
                if (!LoadInstructions) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (LoadInstructions) begin
                    state_nxt = LOADING;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        ready      = (state == READY);
        load_count = wr_ptr;
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else if (load_start) begin
            wr_ptr   <= ONE_C;
            overflow <= 1'b0;
        end else if (load_word) begin
            wr_ptr   <= wr_ptr + ONE_C;
        end else if (load_drop) begin
            overflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset; wr_ptr bounds what is readable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= Instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            InstrOut <= 32'h0;
        end else if (state != READY || LoadInstructions) begin
            InstrOut <= 32'h0;
        end else if (fetch_go) begin
            InstrOut <= fetch_ok ? mem[fetch_idx] : 32'h0;
        end
    end

endmodule

// File: tb/tb_instr_load_sink.sv
// tb/tb_instr_load_sink.sv - scoreboard bench for instr_load_sink
module tb_instr_load_sink;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              Reset;
    logic              LoadInstructions;
    logic [31:0]       Instruction;
    logic              fetch_en;
    logic [31:0]       PC;
    logic [31:0]       InstrOut;
    logic [ADDR_W:0]   load_count;
    logic              ready;
    logic              overflow;

    instr_load_sink #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .fetch_en         (fetch_en),
        .PC               (PC),
        .InstrOut         (InstrOut),
        .load_count       (load_count),
        .ready            (ready),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          cnt;
        logic        rdy;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: a list of loaded words plus a mode word.
    logic [31:0] m_words [DEPTH];
    int          m_count = 0;
    string       m_mode  = "idle";
    logic        m_ovf   = 1'b0;
    logic [31:0] m_out   = 32'h0;

    function automatic void model_step(input logic rst, input logic li,
                                       input logic [31:0] ins, input logic fe,
                                       input logic [31:0] pc);
        if (!rst) begin
            m_count = 0;
            m_mode  = "idle";
            m_ovf   = 1'b0;
            m_out   = 32'h0;
        end else if (li) begin
            if (m_mode != "loading") begin
                m_words[0] = ins;
                m_count    = 1;
                m_ovf      = 1'b0;
                m_mode     = "loading";
            end else if (m_count < DEPTH) begin
                m_words[m_count] = ins;
                m_count          = m_count + 1;
            end else begin
                m_ovf = 1'b1;
            end
            m_out = 32'h0;
        end else if (m_mode == "loading") begin
            m_mode = "ready";
            m_out  = 32'h0;
        end else if (m_mode == "ready") begin
            if (fe) begin
                if (pc % 4 == 0 && (pc / 4) < m_count) m_out = m_words[pc / 4];
                else m_out = 32'h0;
            end
        end else begin
            m_out = 32'h0;
        end
    endfunction

    task automatic cycle(input logic rst, input logic li, input logic [31:0] ins,
                         input logic fe, input logic [31:0] pc);
        exp_t e;
        @(negedge clk);
        Reset            = rst;
        LoadInstructions = li;
        Instruction      = ins;
        fetch_en         = fe;
        PC               = pc;
        model_step(rst, li, ins, fe, pc);
        e.instr = m_out;
        e.cnt   = m_count;
        e.rdy   = (m_mode == "ready");
        e.ovf   = m_ovf;
        sb.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] pc);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, pc);
    endtask

    task automatic idle_cycle();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic load_burst(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, $urandom, 1'b0, 32'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("InstrOut", InstrOut, e.instr);
                check("load_count", 32'(load_count), 32'(e.cnt));
                check("ready", 32'(ready), 32'(e.rdy));
                check("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    logic [31:0] pc_r;
    int          sel;

    initial begin
        Reset = 1'b0; LoadInstructions = 1'b0; Instruction = 32'h0;
        fetch_en = 1'b0; PC = 32'h0;

        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(32'h0);
        fetch(32'h0);

        for (int i = 0; i < 11; i++) begin
            if (i == 0)      cycle(1'b1, 1'b1, 32'h200101A7, 1'b0, 32'h0);
            else if (i == 5) cycle(1'b1, 1'b1, 32'h00242820, 1'b0, 32'h0);
            else             cycle(1'b1, 1'b1, $urandom, 1'b0, 32'h0);
        end
        idle_cycle();
        fetch(32'd0);
        fetch(32'd20);
        fetch(32'd44);
        fetch(32'd2);
        fetch(32'h100);
        fetch(32'd20);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'd0);

        load_burst(DEPTH + 3);
        idle_cycle();
        fetch(32'((DEPTH - 1) * 4));
        fetch(32'd0);

        cycle(1'b1, 1'b1, 32'hAAAA0001, 1'b1, 32'd4);
        cycle(1'b1, 1'b1, 32'hAAAA0002, 1'b0, 32'd0);
        idle_cycle();
        fetch(32'd0);
        fetch(32'd8);
        fetch(32'd4);

        cycle(1'b1, 1'b1, 32'h12345678, 1'b1, 32'd0);
        idle_cycle();
        fetch(32'd0);

        load_burst(5);
        cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'd0);
        fetch(32'd0);
        idle_cycle();

        for (int b = 0; b < 40; b++) begin
            if ($urandom_range(0, 9) == 0) cycle(1'b0, $urandom_range(0, 1), $urandom, 1'b1, 32'd0);
            if ($urandom_range(0, 4) == 0) load_burst($urandom_range(DEPTH - 2, DEPTH + 5));
            else                           load_burst($urandom_range(1, 20));
            for (int c = 0; c < $urandom_range(5, 25); c++) begin
                sel = $urandom_range(0, 9);
                if (sel < 6)       pc_r = 32'($urandom_range(0, DEPTH + 4) * 4);
                else if (sel < 8)  pc_r = 32'($urandom_range(0, 255));
                else               pc_r = $urandom;
                if ($urandom_range(0, 29) == 0)
                    cycle(1'b1, 1'b1, $urandom, 1'b1, pc_r);
                else
                    cycle(1'b1, 1'b0, 32'h0, $urandom_range(0, 3) != 0, pc_r);
            end
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
